// File: rtl/sqrt_seq_pkg.sv
// Shared constants and state encoding for the integer square-root sequencer.
package sqrt_seq_pkg;

  localparam int OP_W   = 16;
  localparam int ROOT_W = 8;
  localparam int REM_W  = 10;

  localparam logic [7:0] OP_ADDR  = 8'd16;
  localparam logic [7:0] RES_ADDR = 8'd18;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RD_HI = 3'd2,
    S_RD_LO = 3'd3,
    S_CALC  = 3'd4,
    S_WR    = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/isqrt_step.sv
// One digit-recurrence iteration of floor(sqrt): shifts in a bit pair and
// decides the next root bit. Purely combinational, no backpressure.
module isqrt_step
  import sqrt_seq_pkg::*;
(
  input  logic [REM_W-1:0]  rem,
  input  logic [ROOT_W-1:0] root,
  input  logic [1:0]        bits,
  output logic [REM_W-1:0]  rem_next,
  output logic [ROOT_W-1:0] root_next
);

  logic [REM_W-1:0] shifted;
  logic [REM_W-1:0] trial;

  assign shifted = {rem[REM_W-3:0], bits};
  assign trial   = {root, 2'b01};

  always_comb begin
    rem_next  = shifted;
    root_next = {root[ROOT_W-2:0], 1'b0};
    if (shifted >= trial) begin
      rem_next  = shifted - trial;
      root_next = {root[ROOT_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/sqrt_seq_ctrl.sv
// Sequencer: reads a 16-bit operand from shared memory, computes the 8-bit root
// in 8 cycles, writes it back; every memory access stalls until MemGnt.
module sqrt_seq_ctrl
  import sqrt_seq_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic       MemReq,
  input  logic       MemGnt,
  output logic [7:0] MemAddr,
  output logic       MemWrEn,
  output logic [7:0] MemWrData,
  input  logic [7:0] MemRdData
);

  state_t            state;
  state_t            next_state;
  logic [OP_W-1:0]   op;
  logic [REM_W-1:0]  rem;
  logic [ROOT_W-1:0] root;
  logic [2:0]        iter;
  logic [REM_W-1:0]  rem_next;
  logic [ROOT_W-1:0] root_next;
  logic [1:0]        bit_pair;

  assign bit_pair = op[{iter, 1'b0} +: 2];

  isqrt_step u_step (
    .rem       (rem),
    .root      (root),
    .bits      (bit_pair),
    .rem_next  (rem_next),
    .root_next (root_next)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (Start)      next_state = S_ARMED;
      S_ARMED: if (!Start)     next_state = S_RD_HI;
      S_RD_HI: if (MemGnt)     next_state = S_RD_LO;
      S_RD_LO: if (MemGnt)     next_state = S_CALC;
      S_CALC:  if (iter == '0) next_state = S_WR;
      S_WR:    if (MemGnt)     next_state = S_DONE;
      S_DONE:  if (Start)      next_state = S_ARMED;
      default:                 next_state = S_IDLE;
    endcase
  end

  // Memory outputs are decoded from state so reset silences them immediately.
  always_comb begin
    MemReq    = 1'b0;
    MemAddr   = 8'd0;
    MemWrEn   = 1'b0;
    MemWrData = 8'd0;
    case (state)
      S_RD_HI: begin
        MemReq  = 1'b1;
        MemAddr = OP_ADDR;
      end
      S_RD_LO: begin
        MemReq  = 1'b1;
        MemAddr = OP_ADDR + 8'd1;
      end
      S_WR: begin
        MemReq    = 1'b1;
        MemAddr   = RES_ADDR;
        MemWrEn   = MemGnt;
        MemWrData = root;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      Ack   <= 1'b0;
      op    <= '0;
      rem   <= '0;
      root  <= '0;
      iter  <= '0;
    end else begin
      state <= next_state;
      Ack   <= (next_state == S_DONE);
      case (state)
        S_RD_HI: if (MemGnt) op[15:8] <= MemRdData;
        S_RD_LO: begin
          if (MemGnt) begin
            op[7:0] <= MemRdData;
            rem     <= '0;
            root    <= '0;
            iter    <= 3'd7;
          end
        end
        S_CALC: begin
          rem  <= rem_next;
          root <= root_next;
          iter <= iter - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Directed bench for sqrt_seq_ctrl with a shared-memory model and a grant
// generator that can withhold MemGnt for a fixed number of cycles per access.
module tb_sqrt_seq_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic       MemReq;
  logic       MemGnt;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;

  logic [7:0] core [256];

  int vectors     = 0;
  int miscompares = 0;
  int n_writes    = 0;
  int stall_cfg   = 0;
  int wait_cnt    = 0;

  always #5 Clk = ~Clk;

  assign MemRdData = core[MemAddr];

  sqrt_seq_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .MemReq    (MemReq),
    .MemGnt    (MemGnt),
    .MemAddr   (MemAddr),
    .MemWrEn   (MemWrEn),
    .MemWrData (MemWrData),
    .MemRdData (MemRdData)
  );

  always @(posedge Clk) begin
    if (MemReq && MemWrEn && MemGnt) begin
      core[MemAddr] = MemWrData;
      n_writes++;
    end
  end

  // Grant generator: withholds MemGnt for stall_cfg cycles at each access.
  always @(negedge Clk) begin
    if (MemWrEn && !MemGnt) begin
      miscompares++;
      $display("FAIL wr_without_gnt: MemWrEn=%b while MemGnt=%b", MemWrEn, MemGnt);
    end
    if (stall_cfg == 0) begin
      MemGnt = 1'b1;
    end else if (MemReq && wait_cnt < stall_cfg) begin
      MemGnt = 1'b0;
      wait_cnt++;
    end else begin
      MemGnt   = MemReq;
      wait_cnt = 0;
    end
  end

  task automatic run_op(input logic [15:0] op, input int stall,
                        output int lat, output logic ack_mid);
    core[16]  = op[15:8];
    core[17]  = op[7:0];
    stall_cfg = stall;
    wait_cnt  = 0;
    n_writes  = 0;
    Start = 1'b1;
    @(posedge Clk); #1;
    ack_mid = Ack;
    @(posedge Clk); #1;
    Start = 1'b0;
    lat = 0;
    while (Ack !== 1'b1 && lat < 200) begin
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    Start = 1'b0;
    MemGnt = 1'b1;
    for (int i = 0; i < 256; i++) core[i] = 8'h00;
    #3;
    vectors++;
    if (Ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", Ack); end
    vectors++;
    if (MemReq !== 1'b0) begin miscompares++; $display("FAIL reset_memreq: got %b want 0", MemReq); end
    vectors++;
    if (MemAddr !== 8'd0) begin miscompares++; $display("FAIL reset_memaddr: got %h want 00", MemAddr); end
    vectors++;
    if (MemWrEn !== 1'b0) begin miscompares++; $display("FAIL reset_wren: got %b want 0", MemWrEn); end
    vectors++;
    if (MemWrData !== 8'd0) begin miscompares++; $display("FAIL reset_wrdata: got %h want 00", MemWrData); end
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    logic am;
    core[18] = 8'hFF;
    run_op(16'd190, 0, lat, am);
    vectors++;
    if (core[18] !== 8'h0D) begin miscompares++; $display("FAIL basic_root: got %h want 0d", core[18]); end
    vectors++;
    if (lat != 12) begin miscompares++; $display("FAIL basic_latency: got %0d want 12", lat); end
    vectors++;
    if (n_writes != 1) begin miscompares++; $display("FAIL basic_writes: got %0d want 1", n_writes); end
  endtask

  task automatic test_boundaries;
    logic [15:0] ops   [5] = '{16'd0, 16'd1, 16'd65024, 16'd65025, 16'd65535};
    logic [7:0]  roots [5] = '{8'd0, 8'd1, 8'd254, 8'd255, 8'd255};
    int lat;
    logic am;
    for (int i = 0; i < 5; i++) begin
      core[18] = 8'hA5;
      run_op(ops[i], 0, lat, am);
      vectors++;
      if (core[18] !== roots[i]) begin
        miscompares++;
        $display("FAIL bound_root op=%0d: got %0d want %0d", ops[i], core[18], roots[i]);
      end
      vectors++;
      if (lat != 12 || n_writes != 1) begin
        miscompares++;
        $display("FAIL bound_timing op=%0d: lat %0d writes %0d want 12/1", ops[i], lat, n_writes);
      end
    end
  endtask

  task automatic test_stall;
    int lat;
    logic am;
    core[18] = 8'h00;
    run_op(16'd190, 3, lat, am);
    vectors++;
    if (core[18] !== 8'h0D) begin miscompares++; $display("FAIL stall_root: got %h want 0d", core[18]); end
    vectors++;
    if (lat != 21) begin miscompares++; $display("FAIL stall_latency: got %0d want 21", lat); end
    vectors++;
    if (n_writes != 1) begin miscompares++; $display("FAIL stall_writes: got %0d want 1", n_writes); end
    stall_cfg = 0;
  endtask

  task automatic test_reset_mid_calc;
    int lat;
    logic am;
    core[18] = 8'h5A;
    core[16] = 8'h00;
    core[17] = 8'hBE;
    n_writes = 0;
    Start = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Start = 1'b0;
    repeat (6) @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    vectors++;
    if (Ack !== 1'b0 || MemReq !== 1'b0 || MemWrEn !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: Ack=%b MemReq=%b MemWrEn=%b want 0/0/0", Ack, MemReq, MemWrEn);
    end
    @(negedge Clk);
    Reset = 1'b0;
    vectors++;
    if (core[18] !== 8'h5A || n_writes != 0) begin
      miscompares++;
      $display("FAIL midreset_nowrite: core18=%h writes=%0d want 5a/0", core[18], n_writes);
    end
    @(posedge Clk); #1;
    run_op(16'd65025, 0, lat, am);
    vectors++;
    if (core[18] !== 8'hFF || lat != 12) begin
      miscompares++;
      $display("FAIL midreset_rerun: root=%h lat=%0d want ff/12", core[18], lat);
    end
  endtask

  task automatic test_start_in_calc;
    int lat;
    core[18] = 8'h00;
    core[16] = 8'hFE;
    core[17] = 8'h00;
    n_writes = 0;
    Start = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Start = 1'b0;
    lat = 0;
    while (Ack !== 1'b1 && lat < 200) begin
      @(posedge Clk); #1;
      lat++;
      if (lat == 5) Start = 1'b1;
      if (lat == 7) Start = 1'b0;
    end
    vectors++;
    if (core[18] !== 8'd254 || lat != 12) begin
      miscompares++;
      $display("FAIL start_in_calc: root=%0d lat=%0d want 254/12", core[18], lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic am;
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if (Ack !== 1'b1) begin miscompares++; $display("FAIL done_hold: Ack=%b want 1", Ack); end
    core[18] = 8'h00;
    run_op(16'd256, 0, lat, am);
    vectors++;
    if (am !== 1'b0) begin miscompares++; $display("FAIL b2b_ack_drop: Ack=%b want 0", am); end
    vectors++;
    if (core[18] !== 8'h10 || lat != 12) begin
      miscompares++;
      $display("FAIL b2b_root: root=%h lat=%0d want 10/12", core[18], lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_stall();
    test_reset_mid_calc();
    test_start_in_calc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
